// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: PC side, program-memory read port and decode/execute handshake.
interface fetch_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] pc_value;
  logic              pc_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_operand;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              flush;

  modport master (
    input  pc_value, mem_rd_ack, mem_rd_data, instr_ready, flush,
    output pc_inc, mem_addr, mem_rd_req, instr_opcode, instr_operand, instr_pc, instr_valid
  );

  modport slave (
    output pc_value, mem_rd_ack, mem_rd_data, instr_ready, flush,
    input  pc_inc, mem_addr, mem_rd_req, instr_opcode, instr_operand, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode/operand bytes at the PC, steps the PC once per byte,
// and holds the assembled instruction until decode/execute accepts it or a flush occurs.
module fetch_unit #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned OPERAND_BIT = 7
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    OP_REQ  = 3'd0,
    OP_INC  = 3'd1,
    ARG_REQ = 3'd2,
    ARG_INC = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] operand_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              req_c;
  logic              inc_c;
  logic              valid_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= OP_REQ;
    else     state <= state_nxt;
  end

  // Next state; flush always restarts at the (reloaded) PC
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = OP_REQ;
    end else begin
      case (state)
        OP_REQ:  if (bus.mem_rd_ack) state_nxt = OP_INC;
        OP_INC:  state_nxt = opcode_q[OPERAND_BIT] ? ARG_REQ : HOLD;
        ARG_REQ: if (bus.mem_rd_ack) state_nxt = ARG_INC;
        ARG_INC: state_nxt = HOLD;
        HOLD:    if (bus.instr_ready) state_nxt = OP_REQ;
        default: state_nxt = OP_REQ;
      endcase
    end
  end

  // Outputs; inc is suppressed on flush so a jump load into the PC is never overridden
  always_comb begin
    req_c   = 1'b0;
    inc_c   = 1'b0;
    valid_c = 1'b0;
    case (state)
      OP_REQ, ARG_REQ: req_c   = !bus.flush && !rst;
      OP_INC, ARG_INC: inc_c   = !bus.flush && !rst;
      HOLD:            valid_c = 1'b1;
      default: ;
    endcase
  end

  // Instruction latches; acks during flush are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
    end else if (!bus.flush && bus.mem_rd_ack) begin
      if (state == OP_REQ) begin
        opcode_q  <= bus.mem_rd_data;
        operand_q <= '0;
        ipc_q     <= bus.pc_value;
      end else if (state == ARG_REQ) begin
        operand_q <= bus.mem_rd_data;
      end
    end
  end

  assign bus.mem_addr      = bus.pc_value;
  assign bus.mem_rd_req    = req_c;
  assign bus.pc_inc        = inc_c;
  assign bus.instr_valid   = valid_c;
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_operand = operand_q;
  assign bus.instr_pc      = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC + memory environment, transaction-level model of the
// expected instruction stream, directed scenarios and a randomized run.
module tb_fetch_unit;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .OPERAND_BIT(7)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [7:0] mem [256];
  logic       load;
  logic [7:0] tgt;

  // PC register: increment has priority over load
  always @(posedge clk) begin
    if (bus.pc_inc === 1'b1) bus.pc_value <= bus.pc_value + 8'd1;
    else if (load)           bus.pc_value <= tgt;
  end

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int tot_inc = 0;

  logic [7:0] fetch_pc;
  int n_acks, n_inc, last_ack;
  bit post_rst, prev_valid, prev_hold_req, prev_drop;
  logic [7:0] p_op, p_arg, p_ipc;
  int wcnt, wtarget, wait_cfg;
  bit rand_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ilen(input logic [7:0] op);
    return op[7] ? 2 : 1;
  endfunction

  task automatic restart(input logic [7:0] t);
    fetch_pc      = t;
    n_acks        = 0;
    n_inc         = 0;
    last_ack      = -100;
    prev_valid    = 1'b0;
    prev_hold_req = 1'b0;
    prev_drop     = 1'b1;
  endtask

  // One clock: drive at negedge, answer memory, then check just before the next posedge
  task automatic step(input bit r, input bit f, input bit rdy, input logic [7:0] t);
    int len;
    logic [7:0] nxt, rd_exp;
    @(negedge clk);
    cyc++;
    rst = r; bus.flush = f; bus.instr_ready = rdy; load = r | f; tgt = t;
    #1;
    if (!r && bus.mem_rd_req === 1'b1) begin
      if (wcnt >= wtarget) begin
        bus.mem_rd_ack  = 1'b1;
        bus.mem_rd_data = mem[bus.mem_addr];
        wcnt    = 0;
        wtarget = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
      end else begin
        bus.mem_rd_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      bus.mem_rd_ack  = (r || f) && ($urandom_range(0, 1) == 1);
      bus.mem_rd_data = 8'($urandom);
    end
    #3;
    if (r) begin
      restart(t);
      post_rst = 1'b1;
    end else begin
      len = ilen(mem[fetch_pc]);
      nxt = fetch_pc + 8'd1;
      chk("mem_addr", 32'(bus.mem_addr), 32'(bus.pc_value));
      if (post_rst) begin
        chk("rst_opcode", 32'(bus.instr_opcode), 32'd0);
        chk("rst_operand", 32'(bus.instr_operand), 32'd0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_req", 32'(bus.mem_rd_req), 32'(!f));
      end
      if (f) begin
        chk("flush_inc", 32'(bus.pc_inc), 32'd0);
        chk("flush_req", 32'(bus.mem_rd_req), 32'd0);
      end
      if (prev_hold_req && !f) chk("req_held", 32'(bus.mem_rd_req), 32'd1);
      if (prev_drop) chk("valid_drop", 32'(bus.instr_valid), 32'd0);
      if (bus.instr_valid === 1'b1) begin
        chk("hold_req", 32'(bus.mem_rd_req), 32'd0);
        chk("hold_inc", 32'(bus.pc_inc), 32'd0);
        if (!prev_valid) begin
          chk("latency", 32'(cyc), 32'(last_ack + 2));
          chk("n_reads", 32'(n_acks), 32'(len));
          chk("n_inc", 32'(n_inc), 32'(len));
          chk("opcode", 32'(bus.instr_opcode), 32'(mem[fetch_pc]));
          chk("operand", 32'(bus.instr_operand), (len == 2) ? 32'(mem[nxt]) : 32'd0);
          chk("instr_pc", 32'(bus.instr_pc), 32'(fetch_pc));
          chk("pc_after", 32'(bus.pc_value), 32'(8'(fetch_pc + 8'(len))));
        end else begin
          chk("stable_opcode", 32'(bus.instr_opcode), 32'(p_op));
          chk("stable_operand", 32'(bus.instr_operand), 32'(p_arg));
          chk("stable_instr_pc", 32'(bus.instr_pc), 32'(p_ipc));
        end
      end
      if (bus.mem_rd_req === 1'b1 && bus.mem_rd_ack === 1'b1) begin
        rd_exp = fetch_pc + 8'(n_acks);
        chk("rd_addr", 32'(bus.mem_addr), 32'(rd_exp));
        chk("rd_count", 32'(n_acks < len), 32'd1);
        n_acks++;
        last_ack = cyc;
      end
      if (bus.pc_inc === 1'b1) begin
        n_inc++;
        tot_inc++;
      end
      prev_hold_req = (bus.mem_rd_req === 1'b1) && (bus.mem_rd_ack !== 1'b1);
      prev_drop     = f || (bus.instr_valid === 1'b1 && rdy);
      prev_valid    = (bus.instr_valid === 1'b1);
      p_op = bus.instr_opcode; p_arg = bus.instr_operand; p_ipc = bus.instr_pc;
      if (f) restart(t);
      else if (bus.instr_valid === 1'b1 && rdy) begin
        fetch_pc = fetch_pc + 8'(len);
        n_acks = 0;
        n_inc  = 0;
      end
      post_rst = 1'b0;
    end
  endtask

  task automatic run_to_valid(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end while (bus.instr_valid !== 1'b1 && n < 60);
    if (bus.instr_valid !== 1'b1) chk("valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic expect_instr(input string tag, input logic [7:0] op, input logic [7:0] arg,
                              input logic [7:0] ipc, input logic [7:0] pc);
    chk({tag, "_opcode"}, 32'(bus.instr_opcode), 32'(op));
    chk({tag, "_operand"}, 32'(bus.instr_operand), 32'(arg));
    chk({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'(ipc));
    chk({tag, "_pc"}, 32'(bus.pc_value), 32'(pc));
  endtask

  initial begin
    int n, inc0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; bus.flush = 1'b0; bus.instr_ready = 1'b0; load = 1'b0; tgt = 8'h00;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_data = 8'h00;
    wait_cfg = 0; wtarget = 0; wcnt = 0; rand_wait = 1'b0;
    restart(8'h00);

    // one-byte instruction after reset
    mem[8'h00] = 8'h12;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    inc0 = tot_inc;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1_req", 32'(bus.mem_rd_req), 32'd1);
    chk("t1_addr", 32'(bus.mem_addr), 32'h00);
    run_to_valid(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_incs", 32'(tot_inc - inc0), 32'd1);
    expect_instr("t1", 8'h12, 8'h00, 8'h00, 8'h01);

    // two-byte instruction, flush+load in HOLD
    mem[8'h05] = 8'h83; mem[8'h06] = 8'h44;
    step(1'b0, 1'b1, 1'b1, 8'h05);
    inc0 = tot_inc;
    run_to_valid(n);
    chk("t2_latency", 32'(n), 32'd5);
    chk("t2_incs", 32'(tot_inc - inc0), 32'd2);
    expect_instr("t2", 8'h83, 8'h44, 8'h05, 8'h07);

    // three wait states on both bytes
    mem[8'h10] = 8'h90; mem[8'h11] = 8'hAB;
    wait_cfg = 3; wtarget = 3;
    step(1'b0, 1'b1, 1'b0, 8'h10);
    inc0 = tot_inc;
    run_to_valid(n);
    chk("t3_latency", 32'(n), 32'd11);
    chk("t3_incs", 32'(tot_inc - inc0), 32'd2);
    expect_instr("t3", 8'h90, 8'hAB, 8'h10, 8'h12);

    // consumer stalls five cycles, then accepts
    inc0 = tot_inc;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4_valid", 32'(bus.instr_valid), 32'd1);
    chk("t4_incs", 32'(tot_inc - inc0), 32'd0);
    expect_instr("t4", 8'h90, 8'hAB, 8'h10, 8'h12);
    wait_cfg = 0; wtarget = 0;
    mem[8'h12] = 8'h05;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t4_req", 32'(bus.mem_rd_req), 32'd1);
    chk("t4_addr", 32'(bus.mem_addr), 32'h12);

    // flush during OP_INC: no inc, restart at jump target
    mem[8'h40] = 8'h01;
    step(1'b0, 1'b1, 1'b0, 8'h40);
    chk("t5_inc", 32'(bus.pc_inc), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t5_req", 32'(bus.mem_rd_req), 32'd1);
    chk("t5_addr", 32'(bus.mem_addr), 32'h40);
    run_to_valid(n);
    expect_instr("t5", 8'h01, 8'h00, 8'h40, 8'h41);

    // wrap: operand of opcode at 0xFF comes from 0x00
    mem[8'hFF] = 8'h81; mem[8'h00] = 8'h07;
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    run_to_valid(n);
    expect_instr("t6", 8'h81, 8'h07, 8'hFF, 8'h01);

    // reset while a read is outstanding
    wait_cfg = 2; wtarget = 2;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h30);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t6_rst_req", 32'(bus.mem_rd_req), 32'd1);
    chk("t6_rst_addr", 32'(bus.mem_addr), 32'h30);
    chk("t6_rst_valid", 32'(bus.instr_valid), 32'd0);

    // randomized traffic
    rand_wait = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      bit r, f, rdy;
      r   = ($urandom_range(0, 249) == 0);
      f   = !r && ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, f, rdy, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Reads the PC value and issues byte reads to program memory over a req/ack handshake.
- Assembles one-byte and two-byte instructions, steps the PC via a single-cycle pc_inc pulse, and presents the instruction to decode/execute with a valid/ready handshake.
- A flush input discards in-flight work when execute reloads the PC on a jump.

Parameters:
- DATA_W, 8, instruction byte width and memory data width.
- ADDR_W, 8, program address width; must equal the PC width.
- OPERAND_BIT, 7, opcode bit that marks a two-byte instruction (1 = an operand byte follows).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- pc_value  in  ADDR_W  current PC register output.
- pc_inc  out  1  PC increment strobe, one cycle per fetched byte.
- mem_addr  out  ADDR_W  program memory read address.
- mem_rd_req  out  1  read request, held until ack.
- mem_rd_ack  in  1  memory ack; mem_rd_data valid in the same cycle.
- mem_rd_data  in  DATA_W  memory read data.
- instr_opcode  out  DATA_W  latched opcode byte.
- instr_operand  out  DATA_W  latched operand byte; 0 for one-byte instructions.
- instr_pc  out  ADDR_W  address of the opcode byte.
- instr_valid  out  1  instruction outputs valid.
- instr_ready  in  1  consumer accepts the instruction.
- flush  in  1  execute is loading a new PC this cycle; discard the current fetch.

Behaviour:
- States: OP_REQ, OP_INC, ARG_REQ, ARG_INC, HOLD. Reset enters OP_REQ.
- Reset values: instr_opcode, instr_operand and instr_pc are 0; instr_valid and pc_inc are 0.
- mem_rd_req is 1 in the first cycle after reset releases, because the FSM is in OP_REQ.
- mem_addr = pc_value, combinational.
- mem_rd_req = 1 only in OP_REQ and ARG_REQ, and only while flush = 0.
- OP_REQ:
  - On ack, latch instr_opcode = mem_rd_data and instr_pc = pc_value, clear instr_operand, then go to OP_INC.
  - Without ack, stay and keep req high.
- OP_INC:
  - pc_inc = 1 for exactly this cycle.
  - If the latched opcode[OPERAND_BIT] = 1, go to ARG_REQ; otherwise go to HOLD.
- ARG_REQ:
  - mem_addr is already the incremented PC.
  - On ack, latch instr_operand, then go to ARG_INC.
- ARG_INC: pc_inc = 1 for one cycle, then go to HOLD.
- HOLD:
  - instr_valid = 1 and all instr_* outputs are stable.
  - On instr_ready = 1, go to OP_REQ; instr_valid drops the next cycle.
- Minimum latency from the OP_REQ ack to instr_valid:
  - one-byte instruction: 2 cycles;
  - two-byte instruction (zero-wait memory): 4 cycles.
- The PC updates at the end of each INC cycle. No request is issued in an INC cycle, so the next address is always post-increment.
- pc_inc = (state is OP_INC or ARG_INC) and not flush. This gating is mandatory because the PC gives increment priority over load, and a simultaneous inc would corrupt a jump.
- Flush, in any state:
  - Next state is OP_REQ and instr_valid is 0 next cycle.
  - An ack in the same cycle is ignored and its data is not latched.
  - No pc_inc is issued in the flush cycle.
  - The next fetch uses the reloaded pc_value.
- Flush together with instr_ready in HOLD: flush wins, and the result is the same as a plain flush.
- rst mid-operation (any state): abort immediately and go to OP_REQ with all outputs at reset values. An outstanding memory ack in that cycle is dropped.
- PC wrap 0xFF -> 0x00 is transparent; a two-byte opcode at 0xFF fetches its operand from 0x00.
- Memory wait states are unbounded; there is no timeout.

Test Plan:
- Reset, zero-wait memory, mem[0x00]=0x12 -> req at 0x00; one pc_inc; instr_valid with opcode 0x12, operand 0x00, instr_pc 0x00 two cycles after ack.
- mem[0x05]=0x83, mem[0x06]=0x44, PC=0x05 -> two pc_inc pulses; valid with opcode 0x83, operand 0x44, instr_pc 0x05; PC ends at 0x07.
- Ack delayed 3 cycles on both bytes of 0x90,0xAB -> req held high and stable throughout; valid asserted 2 cycles after the second ack; exactly two pc_inc pulses.
- Hold instr_ready=0 for 5 cycles in HOLD -> outputs stable, no req, no pc_inc; ready=1 -> next req at the new PC on the following cycle.
- Flush asserted during OP_INC -> pc_inc=0 that cycle; PC loaded to 0x40 by the bench -> next req at 0x40; the stale opcode never appears as valid.
- PC=0xFF holding opcode 0x81, mem[0x00]=0x07 -> operand 0x07 fetched from 0x00; PC ends at 0x01; mid-fetch rst -> req reissued at the new pc_value, instr_valid=0.
